debug_data_streamer: RTL and testbench
======================================

DEBUG_DATA_STREAMER -- requirements
Module: debug_data_streamer

Interface
REQ-001 SHALL have parameter NB_FRAME, default 32: width of one data frame.
REQ-002 SHALL have parameter N_FRAMES, default 3: frames per full strip; strip width NB_STRIP = NB_FRAME*N_FRAMES (96).
REQ-003 SHALL have port i_clock  in  1: the only clock; every register updates on its rising edge.
REQ-004 SHALL have port i_reset  in  1: synchronous, active-low reset.
REQ-005 SHALL have port i_request_select  in  6: source code; 6'b111111 means idle; any other value is a one-cycle request.
REQ-006 SHALL have port i_reg_data  in  NB_FRAME: register-file read data for address o_reg_addr; asynchronous read.
REQ-007 SHALL have port i_pc  in  NB_FRAME: current PC.
REQ-008 SHALL have port i_data_mem_data / i_instr_mem_data  in  NB_FRAME each: memory read data, valid in the request cycle.
REQ-009 SHALL have port i_latch_bus  in  8*NB_STRIP: eight latch strips; strip k is bits [k*NB_STRIP +: NB_STRIP].
REQ-010 SHALL have port o_reg_addr  out  5: i_request_select[4:0] when i_request_select[5]==0, else 0; combinational.
REQ-011 SHALL have port o_frame  out  NB_FRAME: current data frame, registered.
REQ-012 SHALL have port o_eod  out  1: end-of-data pulse, registered.
REQ-013 SHALL have port o_busy  out  1: high in STREAM and EOD states.

Function
REQ-014 SHALL decode: 0zzzzz register; 100000 data memory; 100001 instruction memory; 100010 PC; 100100..101011 latch strip k = select[3:0]-4 (fetch data/ctrl, deco data/ctrl, exec data/ctrl, mem data/ctrl); every other non-idle code is unknown.
REQ-015 SHALL implement FSM IDLE -> STREAM -> EOD -> IDLE.
REQ-016 SHALL, in IDLE, on a valid-source request in cycle T, load a 96-bit shift buffer at edge end-of-T and enter STREAM; single-word sources are loaded as {word, 64'b0}.
REQ-017 SHALL present frame i (MSB-first, frame 0 = buffer[95:64]) on o_frame during cycle T+1+i, using a frame counter 0..N_FRAMES-1.
REQ-018 SHALL enter EOD after the last frame; o_eod is high for exactly one cycle (T+1+N_FRAMES) with o_frame = 0; then return to IDLE.
REQ-019 SHALL handle an unknown code in cycle T by going directly to EOD: zero frames, o_eod high in T+1, o_frame = 0.
REQ-020 SHALL ignore (drop) any non-idle i_request_select arriving while o_busy is high, without disturbing the current strip.
REQ-021 SHALL accept a new request in the same cycle as it returns to IDLE (the cycle after o_eod), giving back-to-back strips with no gap beyond the EOD cycle.
REQ-022 SHALL drive o_frame = 0 in IDLE and in EOD.
REQ-023 SHALL sample all source inputs only at the request edge; source changes during STREAM do not affect emitted frames.

Reset
REQ-024 SHALL, while i_reset==0 at a clock edge, set state IDLE, frame counter 0, buffer 0, o_frame 0, o_eod 0; o_busy 0.
REQ-025 SHALL abort a strip in progress on reset with no o_eod emitted; a request in the same cycle as reset is dropped.

Configuration
REQ-026 SHALL support macro DEBUG_STREAM_COMPACT_EN: when defined, single-word sources (register, PC, memories) emit one frame and then o_eod in T+2; when undefined, every valid source emits N_FRAMES frames, with zero padding for single-word sources; latch strips are unaffected.

Verification
REQ-027 SHALL cover: reset, select=6'b100100, strip0=96'hAAAA_0001_BBBB_0002_CCCC_0003 -> o_frame 32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003 in T+1..T+3; o_eod in T+4.
REQ-028 SHALL cover: select=6'b000101, i_reg_data=32'h1234_5678 -> o_reg_addr=5 in T; frames 12345678, 0, 0; o_eod in T+4 (macro undefined); o_eod in T+2 (macro defined).
REQ-029 SHALL cover: select=6'b101111 (unknown) -> o_eod in T+1, o_frame=0 throughout, o_busy high for 1 cycle.
REQ-030 SHALL cover: select=6'b100010 in T, then select=6'b100000 in T+2 -> second request dropped; PC strip completes unchanged.
REQ-031 SHALL cover: i_reset=0 in T+2 of a latch strip -> o_frame=0, o_eod never asserted, o_busy=0 in T+3.
REQ-032 SHALL cover: back-to-back requests issued in T and T+5 -> two complete strips, each ending in a single-cycle o_eod.

Source files
------------

// File: rtl/debug_data_streamer.sv
// Debug data streamer: captures a register, memory word, PC or latch strip on request
// and shifts it out MSB-first as NB_FRAME-wide frames followed by a one-cycle end-of-data
// pulse. Define DEBUG_STREAM_COMPACT_EN to emit single-word sources as one frame only.
module debug_data_streamer #(
  parameter int NB_FRAME = 32,
  parameter int N_FRAMES = 3
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic [5:0]                   i_request_select,
  input  logic [NB_FRAME-1:0]          i_reg_data,
  input  logic [NB_FRAME-1:0]          i_pc,
  input  logic [NB_FRAME-1:0]          i_data_mem_data,
  input  logic [NB_FRAME-1:0]          i_instr_mem_data,
  input  logic [8*NB_FRAME*N_FRAMES-1:0] i_latch_bus,
  output logic [4:0]                   o_reg_addr,
  output logic [NB_FRAME-1:0]          o_frame,
  output logic                         o_eod,
  output logic                         o_busy
);

  localparam int NB_STRIP = NB_FRAME * N_FRAMES;
  localparam int CW = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1;
  localparam logic [CW-1:0] LAST = CW'(N_FRAMES - 1);

`ifdef DEBUG_STREAM_COMPACT_EN
  localparam bit COMPACT = 1'b1;
`else
  localparam bit COMPACT = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, STREAM, EOD} state_t;

  state_t              state, state_next;
  logic [CW-1:0]       count, count_next;
  logic [NB_STRIP-1:0] buffer, buffer_next;
  logic [NB_FRAME-1:0] frame_next;
  logic                eod_next;
  logic                single, single_next;

  logic                req, src_valid, src_single;
  logic [NB_STRIP-1:0] load;
  logic [3:0]          latch_idx;

  assign o_reg_addr = i_request_select[5] ? 5'd0 : i_request_select[4:0];
  assign o_busy     = (state != IDLE);

  // Source decode: single words are left-aligned in the strip so frame 0 carries them.
  always_comb begin
    req        = (i_request_select != 6'h3F);
    src_valid  = 1'b0;
    src_single = 1'b0;
    load       = '0;
    latch_idx  = i_request_select[3:0] - 4'd4;
    if (!i_request_select[5]) begin
      src_valid  = 1'b1;
      src_single = 1'b1;
      load       = NB_STRIP'(i_reg_data) << (NB_STRIP - NB_FRAME);
    end else if (!i_request_select[4]) begin
      case (i_request_select[3:0])
        4'd0: begin
          src_valid  = 1'b1;
          src_single = 1'b1;
          load       = NB_STRIP'(i_data_mem_data) << (NB_STRIP - NB_FRAME);
        end
        4'd1: begin
          src_valid  = 1'b1;
          src_single = 1'b1;
          load       = NB_STRIP'(i_instr_mem_data) << (NB_STRIP - NB_FRAME);
        end
        4'd2: begin
          src_valid  = 1'b1;
          src_single = 1'b1;
          load       = NB_STRIP'(i_pc) << (NB_STRIP - NB_FRAME);
        end
        4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11: begin
          src_valid = 1'b1;
          for (int k = 0; k < 8; k++) begin
            if (latch_idx[2:0] == 3'(k)) load = i_latch_bus[k*NB_STRIP +: NB_STRIP];
          end
        end
        default: src_valid = 1'b0;
      endcase
    end
  end

  // o_frame always shows the head frame; buffer holds the frames still to come.
  always_comb begin
    state_next  = state;
    count_next  = count;
    buffer_next = buffer;
    frame_next  = '0;
    eod_next    = 1'b0;
    single_next = single;
    case (state)
      IDLE: begin
        if (req) begin
          if (src_valid) begin
            state_next  = STREAM;
            count_next  = '0;
            frame_next  = load[NB_STRIP-1 -: NB_FRAME];
            buffer_next = load << NB_FRAME;
            single_next = src_single;
          end else begin
            state_next = EOD;
            eod_next   = 1'b1;
          end
        end
      end
      STREAM: begin
        if (count == LAST || (COMPACT && single)) begin
          state_next = EOD;
          eod_next   = 1'b1;
        end else begin
          count_next  = count + CW'(1);
          frame_next  = buffer[NB_STRIP-1 -: NB_FRAME];
          buffer_next = buffer << NB_FRAME;
        end
      end
      EOD: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state   <= IDLE;
      count   <= '0;
      buffer  <= '0;
      single  <= 1'b0;
      o_frame <= '0;
      o_eod   <= 1'b0;
    end else begin
      state   <= state_next;
      count   <= count_next;
      buffer  <= buffer_next;
      single  <= single_next;
      o_frame <= frame_next;
      o_eod   <= eod_next;
    end
  end

endmodule

// File: tb/tb_debug_data_streamer.sv
// Self-checking bench for debug_data_streamer: directed scenarios plus randomized
// requests and mid-strip noise, checked against a strip-level reference model.
module tb_debug_data_streamer;

  localparam logic [5:0] IDLE_SEL = 6'h3F;

  logic         i_clock = 1'b0;
  logic         i_reset;
  logic [5:0]   i_request_select;
  logic [31:0]  i_reg_data, i_pc, i_data_mem_data, i_instr_mem_data;
  logic [767:0] i_latch_bus;
  logic [4:0]   o_reg_addr;
  logic [31:0]  o_frame;
  logic         o_eod, o_busy;

  logic [31:0]  reg_file [32];
  int           n_cmp = 0;
  int           n_fail = 0;

  debug_data_streamer dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_request_select(i_request_select),
    .i_reg_data(i_reg_data), .i_pc(i_pc), .i_data_mem_data(i_data_mem_data),
    .i_instr_mem_data(i_instr_mem_data), .i_latch_bus(i_latch_bus),
    .o_reg_addr(o_reg_addr), .o_frame(o_frame), .o_eod(o_eod), .o_busy(o_busy)
  );

  always #5 i_clock = ~i_clock;
  assign i_reg_data = reg_file[o_reg_addr];

  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

  task automatic step();
    @(posedge i_clock);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic randomize_sources();
    i_pc             = $urandom();
    i_data_mem_data  = $urandom();
    i_instr_mem_data = $urandom();
    for (int w = 0; w < 24; w++) i_latch_bus[w*32 +: 32] = $urandom();
    for (int r = 0; r < 32; r++) reg_file[r] = $urandom();
  endtask

  // Reference: what strip a request snapshots and how many frames it yields.
  task automatic model(input logic [5:0] sel, output logic [95:0] strip, output int nf);
    int single_nf;
    int k;
`ifdef DEBUG_STREAM_COMPACT_EN
    single_nf = 1;
`else
    single_nf = 3;
`endif
    strip = '0;
    nf    = 0;
    k     = int'(sel) - 36;
    if (sel < 6'd32) begin
      strip = {reg_file[sel[4:0]], 64'd0}; nf = single_nf;
    end else if (sel == 6'h20) begin
      strip = {i_data_mem_data, 64'd0}; nf = single_nf;
    end else if (sel == 6'h21) begin
      strip = {i_instr_mem_data, 64'd0}; nf = single_nf;
    end else if (sel == 6'h22) begin
      strip = {i_pc, 64'd0}; nf = single_nf;
    end else if (k >= 0 && k <= 7) begin
      strip = i_latch_bus[k*96 +: 96]; nf = 3;
    end
  endtask

  // Issue a request now (cycle T) and check the full strip and return to idle.
  task automatic apply_stimulus(input logic [5:0] sel, input bit noisy);
    logic [95:0] strip;
    int          nf;
    model(sel, strip, nf);
    i_request_select = sel;
    #1;
    check_output("reg_addr", 32'(o_reg_addr), sel[5] ? 32'd0 : 32'(sel % 32));
    check_output("req_busy", 32'(o_busy), 32'd0);
    step();
    for (int i = 0; i < nf; i++) begin
      if (noisy) begin
        randomize_sources();
        i_request_select = 6'($urandom_range(0, 62));
      end else begin
        i_request_select = IDLE_SEL;
      end
      check_output($sformatf("frame%0d", i), o_frame, strip[95 - 32*i -: 32]);
      check_output("stream_busy", 32'(o_busy), 32'd1);
      check_output("stream_eod", 32'(o_eod), 32'd0);
      step();
    end
    check_output("eod_pulse", 32'(o_eod), 32'd1);
    check_output("eod_frame", o_frame, 32'd0);
    check_output("eod_busy", 32'(o_busy), 32'd1);
    i_request_select = IDLE_SEL;
    step();
    check_output("after_eod", 32'(o_eod), 32'd0);
    check_output("after_busy", 32'(o_busy), 32'd0);
    check_output("after_frame", o_frame, 32'd0);
  endtask

  initial begin
    logic [5:0] sel;
    i_reset          = 1'b0;
    i_request_select = IDLE_SEL;
    i_latch_bus      = '0;
    randomize_sources();
    step();
    step();
    check_output("rst_frame", o_frame, 32'd0);
    check_output("rst_eod", 32'(o_eod), 32'd0);
    check_output("rst_busy", 32'(o_busy), 32'd0);
    i_reset = 1'b1;
    step();

    $display("[TB] latch strip 0 directed");
    i_latch_bus[95:0] = 96'hAAAA_0001_BBBB_0002_CCCC_0003;
    apply_stimulus(6'b100100, 1'b0);

    $display("[TB] register 5 directed");
    reg_file[5] = 32'h1234_5678;
    apply_stimulus(6'b000101, 1'b0);

    $display("[TB] unknown code");
    apply_stimulus(6'b101111, 1'b0);

    $display("[TB] PC strip with dropped request and source noise");
    apply_stimulus(6'b100010, 1'b1);

    $display("[TB] back-to-back strips");
    apply_stimulus(6'b100111, 1'b0);
    apply_stimulus(6'b100001, 1'b0);

    $display("[TB] reset mid-strip");
    randomize_sources();
    i_request_select = 6'b101000;
    step();
    i_request_select = IDLE_SEL;
    step();
    i_reset = 1'b0;
    step();
    check_output("abort_frame", o_frame, 32'd0);
    check_output("abort_eod", 32'(o_eod), 32'd0);
    check_output("abort_busy", 32'(o_busy), 32'd0);
    i_request_select = 6'b100010;
    step();
    check_output("rst_req_busy", 32'(o_busy), 32'd0);
    i_reset          = 1'b1;
    i_request_select = IDLE_SEL;
    for (int c = 0; c < 4; c++) begin
      step();
      check_output("post_rst_eod", 32'(o_eod), 32'd0);
      check_output("post_rst_busy", 32'(o_busy), 32'd0);
    end

    $display("[TB] randomized requests");
    for (int n = 0; n < 40; n++) begin
      randomize_sources();
      case ($urandom_range(0, 3))
        0:       sel = {1'b0, 5'($urandom_range(0, 31))};
        1:       sel = 6'(32 + $urandom_range(0, 2));
        2:       sel = 6'(36 + $urandom_range(0, 7));
        default: sel = ($urandom_range(0, 1) == 0) ? 6'h23 : 6'(44 + $urandom_range(0, 18));
      endcase
      apply_stimulus(sel, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
